// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - iterative RV64M multiply/divide unit with stall sequencing
// Radix-2 shift-add multiply and restoring divide over 32 or 64 iterations.
module mdu_sequencer #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [63:0]     instruction,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        f3_q;
  logic              w_q, neg_q;
  logic [XLEN-1:0]   a_q, b_q, result_q, mplier_q;
  logic [2*XLEN-1:0] acc_q, mcand_q;

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

  logic [2:0] funct3;
  logic       is_op, w_bad, accept, unused_instr_bits;
  assign funct3 = instruction[14:12];
  assign is_op  = (instruction[6:0] == 7'b0110011) || (instruction[6:0] == 7'b0111011);
  // W forms of MULH/MULHSU/MULHU do not exist
  assign w_bad  = instruction[3] && !funct3[2] && (funct3[1:0] != 2'b00);
  assign accept = (state_q == S_IDLE) && start && is_op && instruction[25] && !w_bad;
  assign unused_instr_bits = ^{instruction[63:26], instruction[24:15], instruction[11:7]};

  logic            sgn_a, sgn_b, a_neg, b_neg, is_div, is_rem, div_zero, div_ovf;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val, spec_raw, spec_res;
  always_comb begin
    sgn_a = (f3_q == 3'b001) || (f3_q == 3'b010) || (f3_q == 3'b100) || (f3_q == 3'b110);
    sgn_b = (f3_q == 3'b001) || (f3_q == 3'b100) || (f3_q == 3'b110);
    a_ext = a_q;
    b_ext = b_q;
    if (w_q) begin
      a_ext = sgn_a ? sext_w(a_q) : {{(XLEN-32){1'b0}}, a_q[31:0]};
      b_ext = sgn_b ? sext_w(b_q) : {{(XLEN-32){1'b0}}, b_q[31:0]};
    end
    a_neg    = sgn_a && a_ext[XLEN-1];
    b_neg    = sgn_b && b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    is_div   = f3_q[2];
    is_rem   = f3_q[1];
    min_val  = w_q ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = is_div && (b_ext == '0);
    div_ovf  = is_div && !f3_q[0] && (a_ext == min_val) && (b_ext == '1);
    if (div_zero) spec_raw = is_rem ? a_ext : '1;
    else          spec_raw = is_rem ? '0 : a_ext;
    spec_res = w_q ? sext_w(spec_raw) : spec_raw;
  end

  logic [XLEN:0]     rem_sh, rem_sub;
  logic              q_bit;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s, rem_s, fix_raw, fix_res;
  always_comb begin
    rem_sh  = {acc_q[XLEN-1:0], mplier_q[XLEN-1]};
    rem_sub = rem_sh - {1'b0, mcand_q[XLEN-1:0]};
    q_bit   = rem_sh >= {1'b0, mcand_q[XLEN-1:0]};
    prod_s  = neg_q ? -acc_q : acc_q;
    quot_s  = neg_q ? -mplier_q : mplier_q;
    rem_s   = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    case (f3_q)
      3'b000:                 fix_raw = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_raw = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_raw = quot_s;
      default:                fix_raw = rem_s;
    endcase
    fix_res = w_q ? sext_w(fix_raw) : fix_raw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      w_q      <= 1'b0;
      neg_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          f3_q    <= funct3;
          w_q     <= instruction[3];
          a_q     <= rs1_data;
          b_q     <= rs2_data;
          state_q <= S_PREP;
        end
        S_PREP: begin
          neg_q <= (is_div && is_rem) ? a_neg : (a_neg ^ b_neg);
          acc_q <= '0;
          cnt_q <= w_q ? CNT_W'(XLEN/2) : CNT_W'(XLEN);
          // divisor / multiplicand share mcand_q; dividend / multiplier share mplier_q
          if (is_div) begin
            mcand_q  <= {{XLEN{1'b0}}, b_mag};
            mplier_q <= w_q ? (a_mag << 32) : a_mag;
          end else begin
            mcand_q  <= {{XLEN{1'b0}}, a_mag};
            mplier_q <= b_mag;
          end
          if (div_zero || div_ovf) begin
            result_q <= spec_res;
            state_q  <= S_DONE;
          end else begin
            state_q  <= S_ITER;
          end
        end
        S_ITER: begin
          if (is_div) begin
            acc_q    <= {{(XLEN-1){1'b0}}, q_bit ? rem_sub : rem_sh};
            mplier_q <= {mplier_q[XLEN-2:0], q_bit};
          end else begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
          end
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= S_FIX;
        end
        S_FIX: begin
          result_q <= fix_res;
          state_q  <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = (state_q == S_PREP) || (state_q == S_ITER) || (state_q == S_FIX);
  assign done   = (state_q == S_DONE);
  assign stall  = accept || busy || done;
  assign result = result_q;
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - self-checking bench for mdu_sequencer
// Reference model derives results from plain arithmetic and latency from op class.
module tb_mdu_sequencer;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [63:0] instruction = '0, rs1_data = '0, rs2_data = '0;
  logic        stall, busy, done;
  logic [63:0] result;

  mdu_sequencer #(.XLEN(64), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .start(start), .instruction(instruction),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .stall(stall), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] enc(input logic [2:0] f3, input logic w, input logic m);
    return {32'b0, 6'b0, m, 5'd2, 5'd1, f3, 5'd3, (w ? 7'b0111011 : 7'b0110011)};
  endfunction

  function automatic bit accepts(input logic [63:0] ins);
    logic [6:0] op;
    logic [2:0] f;
    op = ins[6:0];
    f  = ins[14:12];
    if (op != 7'h33 && op != 7'h3b) return 1'b0;
    if (!ins[25]) return 1'b0;
    if (op == 7'h3b && (f == 3'd1 || f == 3'd2 || f == 3'd3)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [63:0] model_res(input logic [63:0] ins, input logic [63:0] a, input logic [63:0] b);
    logic [2:0]   f;
    logic [127:0] p;
    logic [63:0]  r;
    logic [31:0]  r32;
    longint       sa, sb;
    int           a32, b32;
    f = ins[14:12];
    sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0];
    r = '0; r32 = '0;
    if (!ins[3]) begin
      case (f)
        3'd0: r = a * b;
        3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
        3'd2: begin p = {{64{a[63]}}, a} * {64'b0, b}; r = p[127:64]; end
        3'd3: begin p = {64'b0, a} * {64'b0, b}; r = p[127:64]; end
        3'd4: if (b == 0) r = '1; else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a; else r = sa / sb;
        3'd5: if (b == 0) r = '1; else r = a / b;
        3'd6: if (b == 0) r = a; else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0; else r = sa % sb;
        default: if (b == 0) r = a; else r = a % b;
      endcase
    end else begin
      case (f)
        3'd0: r32 = a[31:0] * b[31:0];
        3'd4: if (b32 == 0) r32 = '1; else if (a32 == 32'h8000_0000 && b32 == -1) r32 = a[31:0]; else r32 = a32 / b32;
        3'd5: if (b32 == 0) r32 = '1; else r32 = a[31:0] / b[31:0];
        3'd6: if (b32 == 0) r32 = a[31:0]; else if (a32 == 32'h8000_0000 && b32 == -1) r32 = '0; else r32 = a32 % b32;
        default: if (b32 == 0) r32 = a[31:0]; else r32 = a[31:0] % b[31:0];
      endcase
      r = {{32{r32[31]}}, r32};
    end
    return r;
  endfunction

  function automatic int model_lat(input logic [63:0] ins, input logic [63:0] a, input logic [63:0] b);
    logic [2:0] f;
    bit         w, zero, ovf;
    f = ins[14:12];
    w = ins[3];
    if (f[2]) begin
      zero = w ? (b[31:0] == 0) : (b == 0);
      ovf  = !f[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1)
                         : (a == 64'h8000_0000_0000_0000 && b == '1));
      if (zero || ovf) return 2;
    end
    return w ? 35 : 67;
  endfunction

  // m_rem: edges still to go before done is shown
  int          m_rem = 0;
  bit          m_done = 1'b0, m_live = 1'b0;
  logic [63:0] m_res = '0, m_next = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_rem  <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_live <= 1'b1;
    end else begin
      m_done <= (m_rem == 1);
      if (m_rem == 1) m_res <= m_next;
      if (m_rem > 0) m_rem <= m_rem - 1;
      else if (!m_done && start && accepts(instruction)) begin
        m_rem  <= model_lat(instruction, rs1_data, rs2_data) - 1;
        m_next <= model_res(instruction, rs1_data, rs2_data);
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("busy", 64'(busy), 64'(m_rem > 0));
      chk("done", 64'(done), 64'(m_done));
      chk("stall", 64'(stall),
          64'((m_rem > 0) || m_done || ((m_rem == 0) && !m_done && start && accepts(instruction))));
      chk("result", result, m_res);
    end
  end

  task automatic run_op(input string name, input logic [63:0] ins, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_res, input int exp_lat,
                        input bit poke);
    bit got;
    int n;
    got = 1'b0;
    n = 0;
    @(posedge clk); #2;
    instruction = ins; rs1_data = a; rs2_data = b; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    for (int i = 1; i <= 100 && !got; i++) begin
      @(posedge clk); #1;
      if (done) begin got = 1'b1; n = i; end
      #1;
      start = poke && (i == 5);
      if (poke && i == 5) rs1_data = 64'd99;
    end
    start = 1'b0;
    chk({name, "_timeout"}, 64'(got), 64'd1);
    chk({name, "_lat"}, 64'(n + 1), 64'(exp_lat));
    chk({name, "_res"}, result, exp_res);
  endtask

  task automatic ignored(input string name, input logic [63:0] ins);
    bit seen;
    seen = 1'b0;
    @(posedge clk); #2;
    instruction = ins; rs1_data = 64'd5; rs2_data = 64'd6; start = 1'b1;
    #1 chk({name, "_stall"}, 64'(stall), 64'd0);
    @(posedge clk); #2;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk({name, "_noop"}, 64'(seen), 64'd0);
  endtask

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);

    run_op("mul",     enc(3'd0, 1'b0, 1'b1), 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 67, 1'b0);
    run_op("mulhu",   enc(3'd3, 1'b0, 1'b1), '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 67, 1'b1);
    run_op("mulh",    enc(3'd1, 1'b0, 1'b1), '1, '1, 64'd0, 67, 1'b0);
    run_op("mulhsu",  enc(3'd2, 1'b0, 1'b1), '1, 64'd2, '1, 67, 1'b0);
    run_op("div",     enc(3'd4, 1'b0, 1'b1), 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 67, 1'b1);
    run_op("rem",     enc(3'd6, 1'b0, 1'b1), 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 67, 1'b0);
    run_op("divuw",   enc(3'd5, 1'b1, 1'b1), 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 35, 1'b0);
    run_op("mulw",    enc(3'd0, 1'b1, 1'b1), 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 35, 1'b0);
    run_op("remw",    enc(3'd6, 1'b1, 1'b1), 64'h0000_0000_FFFF_FFF9, 64'd2, '1, 35, 1'b0);
    run_op("divu0",   enc(3'd5, 1'b0, 1'b1), 64'h1234, 64'd0, '1, 2, 1'b0);
    run_op("removf",  enc(3'd6, 1'b0, 1'b1), 64'h8000_0000_0000_0000, '1, 64'd0, 2, 1'b0);
    run_op("divovf",  enc(3'd4, 1'b0, 1'b1), 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 2, 1'b0);
    run_op("divwovf", enc(3'd4, 1'b1, 1'b1), 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 2, 1'b0);
    run_op("remuw0",  enc(3'd7, 1'b1, 1'b1), 64'h0000_0001_FFFF_FFF0, 64'h0000_0005_0000_0000, 64'hFFFF_FFFF_FFFF_FFF0, 2, 1'b0);

    ignored("add", enc(3'd0, 1'b0, 1'b0));
    ignored("mulhw", enc(3'd1, 1'b1, 1'b1));

    // abandon a multiply partway through ITER
    @(posedge clk); #2;
    instruction = enc(3'd0, 1'b0, 1'b1); rs1_data = 64'd3; rs2_data = 64'd5; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_result", result, 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    #1 reset = 1'b0;
    seen = 1'b0;
    repeat (70) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("midrst_nodone", 64'(seen), 64'd0);
    run_op("after_rst", enc(3'd4, 1'b0, 1'b1), 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 67, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Iterative RV64M multiply/divide unit and its sequencing controller; sits beside the ALU in the execute stage.
- Decodes M-extension instructions from the 64-bit instruction word, runs a radix-2 shift-add/shift-subtract datapath over multiple cycles, and asserts stall so the single-cycle core holds PC and register writeback until the result is ready.
- Handles all RISC-V special cases (divide-by-zero, signed overflow) and the 32-bit W variants.

Parameters:
- XLEN, 64, operand/result width; only 64 is supported.
- CNT_W, 7, iteration counter width; must hold the value 64.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- start  input  1  execute stage presents a candidate instruction this cycle
- instruction  input  64  current instruction word; uses bits [3], [14:12], [25] and [6:0]
- rs1_data  input  64  operand A (dividend / multiplicand)
- rs2_data  input  64  operand B (divisor / multiplier)
- stall  output  1  hold PC and writeback; combinational
- busy  output  1  sequencer is in PREP, ITER or FIX
- done  output  1  one-cycle pulse; result is valid for writeback
- result  output  64  final result; held until the next accepted start

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, counter=0, all internal registers 0. A reset taken mid-operation abandons the operation; no done is produced.
- Accept condition (accept): state==IDLE & start & instruction[6:0] in {0110011, 0111011} & instruction[25]==1.
- W-variant decode: instruction[3]==1 marks a W op. For W ops, funct3 (instruction[14:12]) in {001, 010, 011} is not accepted.
- Non-accepted starts are ignored entirely.
- stall = accept | busy | done. Writeback occurs in the done cycle, and stall drops in the cycle after done.
- A start that arrives while busy or done is ignored.
- FSM: IDLE -> PREP (on accept) -> ITER (N cycles) -> FIX -> DONE -> IDLE.
  - N=64 for 64-bit ops; N=32 for W ops.
  - DONE lasts exactly one cycle with done=1.
- Operation register: captures funct3, the W flag, rs1_data and rs2_data at the accepting edge.
- PREP:
  - Take operand magnitudes per signedness: MULH signs both; MULHSU signs A only; MULHU, DIVU and REMU are unsigned; MUL ignores sign.
  - W ops first sign-extend (signed) or zero-extend (unsigned) the low 32 bits.
  - Record the result-negate flag.
  - Special-case check in PREP:
    - Divisor==0: quotient = all ones (W: 0xFFFFFFFF, then sign-extended), remainder = dividend.
    - Signed overflow (dividend = most-negative value, divisor = -1): quotient = dividend, remainder = 0.
    - Either case goes PREP -> DONE directly, skipping ITER and FIX.
- ITER, multiply: 128-bit accumulator. Each cycle, add the shifted multiplicand if the multiplier LSB is 1, then shift.
- ITER, divide: restoring division. Each cycle, shift the remainder left by 1, bring in the next dividend bit, subtract the divisor if the remainder >= divisor, and set the quotient bit.
- Counter: loaded with N in PREP, decremented in ITER; leave ITER when counter reaches 1.
- FIX: apply two's-complement negate when flagged.
  - Quotient sign = signA ^ signB. Remainder sign = signA.
  - Result selection: MUL takes product[63:0]; MULH/MULHSU/MULHU take product[127:64]; DIV/DIVU take the quotient; REM/REMU take the remainder.
  - W ops: result = sign-extension of result bit 31.
- Latency, measured from the accepting edge to the edge that ends done:
  - Normal 64-bit op: 67 cycles.
  - Normal W op: 35 cycles.
  - Special case: 2 cycles.
- result: updated only on entry to DONE; stable otherwise.

Test Plan:
- MUL 0x7 * 0xFFFFFFFFFFFFFFFD (-3), start for one cycle -> busy for 66 cycles, done pulse once, result=0xFFFFFFFFFFFFFFEB, stall low the cycle after done.
- MULHU 0xFFFFFFFFFFFFFFFF * 0xFFFFFFFFFFFFFFFF -> result=0xFFFFFFFFFFFFFFFE; MULH with the same operands -> result=0.
- DIV -7 / 2 -> result=0xFFFFFFFFFFFFFFFD; REM -7 / 2 -> result=0xFFFFFFFFFFFFFFFF; DIVUW 0x00000000_80000000 / 1 -> result=0xFFFFFFFF80000000, latency 35.
- DIVU x / 0 -> result=0xFFFFFFFFFFFFFFFF, done on the 2nd cycle after accept. REM 0x8000000000000000 / -1 -> result=0. DIV with the same operands -> result=0x8000000000000000.
- Ignored inputs: start with ADD (instruction[25]=0) -> stall=0, no done. Start asserted again while busy -> ignored, only one done, result unchanged. Funct3=001 with OP-32 -> not accepted.
- Reset asserted at ITER cycle 10 -> next cycle busy=0, result=0, no done; a fresh start afterwards completes normally.
